dequ_float_packer: RTL and testbench

Multi-lane, parametrised integer-to-float packer for the dequantizer output path. Each beat carries LANES signed integer lanes and one shared power-of-two step exponent; every lane is converted to an IEEE-style float (sign, biased exponent, rounded mantissa) with overflow/underflow flags. The block sits between the dequantizer integer datapath and the L2 writeback, behind a valid/ready handshake with a 3-stage elastic pipeline.

---
 rtl/dequ_pkg.sv | 31 +++
 rtl/dequ_lzd.sv | 22 ++
 rtl/dequ_float_packer.sv | 209 ++++++++++++++++++++
 tb/tb_dequ_float_packer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dequ_pkg.sv
// Shared defaults, derived-width helpers and the lane result layout for the
// dequantizer integer-to-float packer.
package dequ_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int DEF_BIAS  = 127;

    function automatic int flt_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    typedef struct packed {
        logic                 sign;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_MAN_W-1:0] man;
        logic                 ovf;
        logic                 unf;
    } lane_res_t;

endpackage

// File: rtl/dequ_lzd.sv
// Leading-one detector: index of the most significant set bit, plus a flag
// for an all-zero input (index is 0 in that case).
module dequ_lzd #(
    parameter int W  = 32,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  data,
    output logic [IW-1:0] idx,
    output logic          zero
);

    always_comb begin
        idx  = '0;
        zero = ~|data;
        for (int i = 0; i < W; i++) begin
            if (data[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/dequ_float_packer.sv
// Multi-lane signed integer to float packer with a shared power-of-two step,
// built as a 3-stage elastic pipeline (abs, normalise, round/pack).
module dequ_float_packer
    import dequ_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int INT_W  = 32,
    parameter int STEP_W = 8,
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MAN_W  = DEF_MAN_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*INT_W-1:0]       in_data,
    input  logic [STEP_W-1:0]            in_step_exp,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*flt_w(EXP_W, MAN_W)-1:0] out_data,
    output logic [LANES-1:0]             out_ovf,
    output logic [LANES-1:0]             out_unf,
    output logic                         out_last
);

    localparam int FLT_W  = flt_w(EXP_W, MAN_W);
    localparam int BIAS   = bias_of(EXP_W);
    localparam int PW     = $clog2(INT_W);
    localparam int EW     = max3(STEP_W, PW, EXP_W) + 2;
    localparam int FRAC_W = INT_W - 1;
    localparam int DROP_W = (FRAC_W > MAN_W) ? FRAC_W - MAN_W : 0;
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

    // Handshake: a beat moves across any boundary when valid && ready at a
    // rising edge. A stage loads when it is empty or the stage after it loads;
    // the output stage loads when empty or out_ready. in_ready is the S1 load
    // condition, so it may follow out_ready combinationally.
    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    assign ld3       = !v3 || out_ready;
    assign ld2       = !v2 || ld3;
    assign ld1       = !v1 || ld2;
    assign in_ready  = ld1;
    assign out_valid = v3;

    logic [LANES-1:0][INT_W-1:0]  in_lane;
    logic [LANES-1:0][INT_W-1:0]  abs_c;
    logic [LANES-1:0][INT_W-1:0]  s1_abs;
    logic [LANES-1:0]             s1_sign;
    logic [STEP_W-1:0]            s1_step;
    logic                         s1_last;

    logic [LANES-1:0][PW-1:0]     p_c;
    logic [LANES-1:0]             z_c;
    logic [LANES-1:0][FRAC_W-1:0] frac_c;
    logic [LANES-1:0][FRAC_W-1:0] s2_frac;
    logic [LANES-1:0][PW-1:0]     s2_p;
    logic [LANES-1:0]             s2_zero;
    logic [LANES-1:0]             s2_sign;
    logic [STEP_W-1:0]            s2_step;
    logic                         s2_last;

    logic [LANES-1:0][FLT_W-1:0]  res_flt;
    logic [LANES-1:0]             res_ovf;
    logic [LANES-1:0]             res_unf;
    logic [LANES-1:0][FLT_W-1:0]  out_q;

    assign in_lane = in_data;

    // Magnitude as unsigned INT_W bits; the most negative input maps to 2^(INT_W-1).
    always_comb begin
        abs_c = '0;
        for (int i = 0; i < LANES; i++) begin
            abs_c[i] = in_lane[i][INT_W-1] ? ('0 - in_lane[i]) : in_lane[i];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dequ_lzd #(.W(INT_W), .IW(PW)) u_lzd (
            .data (s1_abs[g]),
            .idx  (p_c[g]),
            .zero (z_c[g])
        );

        // Shifting the leading one to the top drops it; the rest is the fraction.
        assign frac_c[g] = FRAC_W'(s1_abs[g] << (PW'(INT_W - 1) - p_c[g]));

        logic [FRAC_W-1:0]    frac;
        logic [MAN_W-1:0]     man_raw;
        logic                 rnd_up;
        logic [MAN_W:0]       man_sum;
        logic signed [EW-1:0] e_full;
        logic                 ovf_c;
        logic                 unf_c;
        logic                 r_sign;
        logic [EXP_W-1:0]     r_exp;
        logic [MAN_W-1:0]     r_man;
        logic                 r_ovf;
        logic                 r_unf;

        assign frac = s2_frac[g];

        if (DROP_W > 0) begin : g_rnd
            logic guard;
            logic sticky;
            assign man_raw = frac[FRAC_W-1 -: MAN_W];
            assign guard   = frac[DROP_W-1];
            if (DROP_W > 1) begin : g_sticky
                assign sticky = |frac[DROP_W-2:0];
            end else begin : g_nosticky
                assign sticky = 1'b0;
            end
            assign rnd_up = guard && (sticky || man_raw[0]);
        end else begin : g_pad
            assign man_raw = MAN_W'(frac) << (MAN_W - FRAC_W);
            assign rnd_up  = 1'b0;
        end

        assign man_sum = {1'b0, man_raw} + {{MAN_W{1'b0}}, rnd_up};
        assign e_full  = EW'(BIAS)
                       + {{(EW-STEP_W){s2_step[STEP_W-1]}}, s2_step}
                       + {{(EW-PW){1'b0}}, s2_p[g]}
                       + {{(EW-1){1'b0}}, man_sum[MAN_W]};
        assign ovf_c   = !e_full[EW-1] && (e_full >= E_MAX);
        assign unf_c   = e_full[EW-1] || (e_full == '0);

        always_comb begin
            r_sign = s2_sign[g];
            r_exp  = '0;
            r_man  = '0;
            r_ovf  = 1'b0;
            r_unf  = 1'b0;
            if (s2_zero[g]) begin
                r_sign = 1'b0;
            end else if (ovf_c) begin
                r_exp = '1;
                r_ovf = 1'b1;
            end else if (unf_c) begin
                r_unf = 1'b1;
            end else begin
                r_exp = e_full[EXP_W-1:0];
                r_man = man_sum[MAN_W-1:0];
            end
        end

        assign res_flt[g] = {r_sign, r_exp, r_man};
        assign res_ovf[g] = r_ovf;
        assign res_unf[g] = r_unf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            s1_abs   <= '0;
            s1_sign  <= '0;
            s1_step  <= '0;
            s1_last  <= 1'b0;
            s2_frac  <= '0;
            s2_p     <= '0;
            s2_zero  <= '0;
            s2_sign  <= '0;
            s2_step  <= '0;
            s2_last  <= 1'b0;
            out_q    <= '0;
            out_ovf  <= '0;
            out_unf  <= '0;
            out_last <= 1'b0;
        end else begin
            if (ld1) begin
                v1 <= in_valid;
            end
            if (ld1 && in_valid) begin
                s1_abs  <= abs_c;
                for (int i = 0; i < LANES; i++) begin
                    s1_sign[i] <= in_lane[i][INT_W-1];
                end
                s1_step <= in_step_exp;
                s1_last <= in_last;
            end
            if (ld2) begin
                v2 <= v1;
            end
            if (ld2 && v1) begin
                s2_frac <= frac_c;
                s2_p    <= p_c;
                s2_zero <= z_c;
                s2_sign <= s1_sign;
                s2_step <= s1_step;
                s2_last <= s1_last;
            end
            if (ld3) begin
                v3 <= v2;
            end
            if (ld3 && v2) begin
                out_q    <= res_flt;
                out_ovf  <= res_ovf;
                out_unf  <= res_unf;
                out_last <= s2_last;
            end
        end
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_dequ_float_packer.sv
// Directed bench for dequ_float_packer: hand-computed float vectors, a
// scoreboard queue of expected beats, stall/backpressure and mid-stream reset.
module tb_dequ_float_packer;

    localparam int LANES  = 16;
    localparam int INT_W  = 32;
    localparam int STEP_W = 8;
    localparam int FLT_W  = 32;
    localparam int SB_W   = 1 + 2*LANES + LANES*FLT_W;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*INT_W-1:0] in_data;
    logic [STEP_W-1:0]      in_step_exp;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*FLT_W-1:0] out_data;
    logic [LANES-1:0]       out_ovf;
    logic [LANES-1:0]       out_unf;
    logic                   out_last;

    dequ_float_packer #(
        .LANES(LANES), .INT_W(INT_W), .STEP_W(STEP_W), .EXP_W(8), .MAN_W(23)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_step_exp(in_step_exp), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_unf(out_unf), .out_last(out_last)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_beats = 0;

    logic [SB_W-1:0] exp_q[$];

    logic [LANES-1:0][INT_W-1:0] tv_d;
    logic [LANES-1:0][FLT_W-1:0] tv_f;
    logic [LANES-1:0]            tv_o;
    logic [LANES-1:0]            tv_u;
    logic [STEP_W-1:0]           tv_step;
    logic                        tv_last;
    logic [SB_W-1:0]             cur_exp;
    logic [SB_W-1:0]             mon_e;

    logic [31:0] pos_tab[5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    logic [31:0] neg_tab[5] = '{32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hC0A00000};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // driver tasks
    task automatic clear_vec();
        tv_d = '0; tv_f = '0; tv_o = '0; tv_u = '0;
        tv_step = '0; tv_last = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic [31:0] v, input logic [31:0] f,
                            input logic o, input logic u);
        tv_d[i] = v; tv_f[i] = f; tv_o[i] = o; tv_u[i] = u;
    endtask

    task automatic drive();
        in_data     = tv_d;
        in_step_exp = tv_step;
        in_last     = tv_last;
        in_valid    = 1'b1;
        cur_exp     = {tv_last, tv_u, tv_o, tv_f};
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send();
        int   waited;
        logic acc;
        waited = 0;
        acc    = 1'b0;
        drive();
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        check("accept", 64'(acc), 64'd1);
        if (acc) exp_q.push_back(cur_exp);
        in_valid = 1'b0;
    endtask

    task automatic setup_a();
        clear_vec();
        set_lane(0, 32'h00000001, 32'h3F800000, 0, 0);
        set_lane(1, 32'h7FFFFFFF, 32'h4F000000, 0, 0);
        set_lane(2, 32'h80000000, 32'hCF000000, 0, 0);
        set_lane(3, 32'h00000000, 32'h00000000, 0, 0);
        set_lane(4, 32'hFFFFFFFF, 32'hBF800000, 0, 0);
        set_lane(5, 32'h00000003, 32'h40400000, 0, 0);
        set_lane(6, 32'h01000001, 32'h4B800000, 0, 0);
        set_lane(7, 32'h01000003, 32'h4B800002, 0, 0);
        set_lane(8, 32'h00000064, 32'h42C80000, 0, 0);
        set_lane(9, 32'h01FFFFFF, 32'h4C000000, 0, 0);
    endtask

    task automatic setup_b();
        clear_vec();
        tv_step = 8'hFE;
        tv_last = 1'b1;
        set_lane(0, 32'hFFFFFFFA, 32'hBFC00000, 0, 0);
        set_lane(1, 32'h00000001, 32'h3E800000, 0, 0);
    endtask

    task automatic setup_c();
        clear_vec();
        tv_step = 8'h7F;
        set_lane(0, 32'h00000001, 32'h7F000000, 0, 0);
        set_lane(1, 32'h00000002, 32'h7F800000, 1, 0);
        set_lane(2, 32'hFFFFFFFE, 32'hFF800000, 1, 0);
    endtask

    task automatic setup_d();
        clear_vec();
        tv_step = 8'h81;
        set_lane(0, 32'h00000001, 32'h00000000, 0, 1);
        set_lane(1, 32'hFFFFFFFF, 32'h80000000, 0, 1);
        set_lane(2, 32'h00000002, 32'h00800000, 0, 0);
        set_lane(3, 32'h01000000, 32'h0C000000, 0, 0);
    endtask

    task automatic setup_stall(input int k);
        clear_vec();
        tv_last = (k == 3 || k == 5);
        set_lane(0, 32'(k), pos_tab[k-1], 0, 0);
        set_lane(15, 32'(0) - 32'(k), neg_tab[k-1], 0, 0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 30) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                for (int i = 0; i < LANES; i++) begin
                    check($sformatf("b%0d_lane%0d", rx_beats, i),
                          64'(out_data[i*FLT_W +: FLT_W]), 64'(mon_e[i*FLT_W +: FLT_W]));
                end
                check($sformatf("b%0d_ovf", rx_beats), 64'(out_ovf), 64'(mon_e[LANES*FLT_W +: LANES]));
                check($sformatf("b%0d_unf", rx_beats), 64'(out_unf), 64'(mon_e[LANES*FLT_W+LANES +: LANES]));
                check($sformatf("b%0d_last", rx_beats), 64'(out_last), 64'(mon_e[SB_W-1]));
            end
            rx_beats++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   idx;
        int   guard;
        int   stale;
        logic acc;
        logic have_snap;
        logic [63:0] snap;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_step_exp = '0;
        in_last = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data[63:0]), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        check("rst_out_unf", 64'(out_unf), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        #10;
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // first-beat latency: presented, accepted on the next edge, visible 3 edges on
        setup_a();
        drive();
        @(negedge clk);
        check("lat_in_ready", 64'(in_ready), 64'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                in_valid = 1'b0;
                exp_q.push_back(cur_exp);
            end
        end while (!out_valid && lat < 10);
        check("latency", 64'(lat), 64'd3);

        setup_b(); send();
        setup_c(); send();
        setup_d(); send();
        drain();

        // same vectors under random backpressure
        fork
            begin
                setup_a(); send();
                setup_b(); send();
                setup_c(); send();
                setup_d(); send();
            end
            begin
                repeat (30) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // stall: 6 cycles of out_ready low while 5 beats are offered
        out_ready = 1'b0;
        idx = 0;
        have_snap = 1'b0;
        snap = '0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 5) begin
                setup_stall(idx + 1);
                drive();
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            acc = in_ready && in_valid;
            if (out_valid) begin
                if (!have_snap) begin
                    snap = {out_data[15*FLT_W +: FLT_W], out_data[FLT_W-1:0]};
                    have_snap = 1'b1;
                end else begin
                    check("stall_hold", {out_data[15*FLT_W +: FLT_W], out_data[FLT_W-1:0]}, snap);
                end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(cur_exp);
                idx++;
            end
        end
        check("stall_accepted", 64'(idx), 64'd3);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);

        out_ready = 1'b1;
        guard = 0;
        while (idx < 5 && guard < 50) begin
            setup_stall(idx + 1);
            drive();
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(cur_exp);
                idx++;
            end
            guard++;
        end
        in_valid = 1'b0;
        check("release_accepted", 64'(idx), 64'd5);
        drain();

        // reset with beats in flight
        out_ready = 1'b0;
        clear_vec();
        tv_step = 8'h7F;
        tv_last = 1'b1;
        set_lane(0, 32'h00000001, 32'h7F000000, 0, 0);
        set_lane(1, 32'h00000002, 32'h7F800000, 1, 0);
        send();
        send();
        guard = 0;
        while (!out_valid && guard < 5) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("rst_pre_valid", 64'(out_valid), 64'd1);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data", 64'(out_data[63:0]), 64'd0);
        check("arst_out_ovf", 64'(out_ovf), 64'd0);
        check("arst_out_unf", 64'(out_unf), 64'd0);
        check("arst_out_last", 64'(out_last), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale_beat", 64'(stale), 64'd0);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
